// File: rtl/dac_control_if.sv
// dac_control_if: EBI-side register bus of the DAC controller.
// The host (master) drives the address, write data and strobe; the block returns read data and busy.
interface dac_control_if;
    logic [18:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic [15:0] data_out;
    logic        busy;

    modport master (output addr, data_in, wr, input  data_out, busy);
    modport slave  (input  addr, data_in, wr, output data_out, busy);
endinterface

// File: rtl/dac_control.sv
// dac_control: EBI-written frame FIFO serialised to an 8-channel 12-bit SYNC/SCLK/DIN/LDAC DAC.
// Optional macro DAC_SHADOW_EN adds readable 12-bit per-channel shadow registers.
module dac_control #(
    parameter int POSITION   = 0,
    parameter int CLK_DIV    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    dac_control_if.slave ebi,
    output logic         dac_cs_n,
    output logic         dac_sclk,
    output logic         dac_din,
    output logic         dac_ldac_n
);
    localparam logic [18:0] BASE_ADDR = 19'(POSITION << 8);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    LDAC_LAST = CW'(2 * CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_LDAC  = 2'd3;

    logic             in_win_s, ctrl_wr_s, ch_wr_s, push_s, pop_s, full_s, ldac_done_s;
    logic [7:0]       off_s;
    logic [2:0]       ch_idx_s;
    logic [15:0]      rd_data_s;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r, ldac_pending_r, busy_r;
    logic [15:0]      data_out_r, shift_r;
    logic [1:0]       state_r;
    logic [CW-1:0]    div_r;
    logic [4:0]       half_r;

    assign in_win_s    = (ebi.addr[18:8] == BASE_ADDR[18:8]);
    assign off_s       = ebi.addr[7:0];
    assign ch_idx_s    = 3'(off_s - 8'd2);
    assign full_s      = (count_r == DEPTH_C);
    assign pop_s       = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
    assign push_s      = ch_wr_s && (!full_s || pop_s);
    assign ldac_done_s = (state_r == ST_LDAC) && (div_r == LDAC_LAST);

    // Decode write strobes for the CTRL register and the channel windows.
    always_comb begin
        ctrl_wr_s = 1'b0;
        ch_wr_s   = 1'b0;
        if (ebi.wr && in_win_s) begin
            if (off_s == 8'd0) begin
                ctrl_wr_s = 1'b1;
            end else if ((off_s >= 8'd2) && (off_s <= 8'd9)) begin
                ch_wr_s = 1'b1;
            end else begin
                ctrl_wr_s = 1'b0;
            end
        end else begin
            ch_wr_s = 1'b0;
        end
    end

    // Frame FIFO pointers and occupancy; flush empties it without touching the engine.
    always_ff @(posedge clk) begin
        if (reset || (ctrl_wr_s && ebi.data_in[0])) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO storage; frame bit 15 is always 0, then channel, then the 12-bit code.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem[wr_ptr_r] <= {1'b0, ch_idx_s, ebi.data_in[11:0]};
    end

    // Sticky overflow and merged LDAC request flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r     <= 1'b0;
            ldac_pending_r <= 1'b0;
        end else begin
            if (ch_wr_s && !push_s)                    overflow_r <= 1'b1;
            else if (ctrl_wr_s && ebi.data_in[2])      overflow_r <= 1'b0;
            if (ldac_done_s)                           ldac_pending_r <= 1'b0;
            else if (ctrl_wr_s && ebi.data_in[1])      ldac_pending_r <= 1'b1;
        end
    end

    // Serial engine: the divider restarts at each state entry, half_r counts SCLK half-periods.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            dac_ldac_n <= 1'b1;
            div_r      <= '0;
            half_r     <= 5'd0;
            shift_r    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_r  <= '0;
                    half_r <= 5'd0;
                    if (pop_s) begin
                        state_r  <= ST_SHIFT;
                        shift_r  <= fifo_mem[rd_ptr_r];
                        dac_din  <= fifo_mem[rd_ptr_r][15];
                        dac_cs_n <= 1'b0;
                    end else if (ldac_pending_r) begin
                        state_r    <= ST_LDAC;
                        dac_ldac_n <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_r == DIV_LAST) begin
                        div_r  <= '0;
                        half_r <= half_r + 5'd1;
                        if (!half_r[0]) begin
                            dac_sclk <= 1'b0;
                        end else begin
                            dac_sclk <= 1'b1;
                            shift_r  <= {shift_r[14:0], 1'b0};
                            dac_din  <= shift_r[14];
                            // The 16th rising edge also closes the frame.
                            if (half_r == 5'd31) begin
                                dac_cs_n <= 1'b1;
                                dac_din  <= 1'b0;
                                state_r  <= ST_GAP;
                            end
                        end
                    end else begin
                        div_r <= div_r + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (div_r == DIV_LAST) begin
                        div_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        div_r <= div_r + CW'(1);
                    end
                end
                ST_LDAC: begin
                    if (ldac_done_s) begin
                        div_r      <= '0;
                        dac_ldac_n <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        div_r <= div_r + CW'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef DAC_SHADOW_EN
    logic [11:0] shadow_r [8];

    // Shadow copy of every accepted channel code; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) shadow_r[i] <= 12'd0;
        end else if (push_s) begin
            shadow_r[ch_idx_s] <= ebi.data_in[11:0];
        end
    end
`endif

    // Read mux for the registered data_out.
    always_comb begin
        rd_data_s = 16'd0;
        if (in_win_s) begin
            case (off_s)
                8'd1: rd_data_s = {busy_r, overflow_r, ldac_pending_r, 8'd0, 5'(count_r)};
`ifdef DAC_SHADOW_EN
                8'd2, 8'd3, 8'd4, 8'd5,
                8'd6, 8'd7, 8'd8, 8'd9: rd_data_s = {4'd0, shadow_r[ch_idx_s]};
`endif
                default: rd_data_s = 16'd0;
            endcase
        end else begin
            rd_data_s = 16'd0;
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= 16'd0;
            busy_r     <= 1'b0;
        end else begin
            data_out_r <= rd_data_s;
            busy_r     <= (state_r != ST_IDLE) || (count_r != CNT_ZERO) || ldac_pending_r;
        end
    end

    assign ebi.data_out = data_out_r;
    assign ebi.busy     = busy_r;
endmodule

// File: tb/tb_dac_control.sv
// tb_dac_control: vector table, hand-written corner sequences and randomized frames for dac_control.
// A line monitor decodes frames/LDAC pulses independently of the RTL.
module tb_dac_control;
    localparam int          POS    = 1;
    localparam int          CD     = 5;
    localparam logic [18:0] BASE   = 19'h00100;
    localparam int          PERIOD = 33 * CD + 1;

    logic clk = 1'b0;
    logic reset;
    logic dac_cs_n, dac_sclk, dac_din, dac_ldac_n;
    dac_control_if ebi ();

    dac_control #(.POSITION(POS), .CLK_DIV(CD), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .ebi(ebi),
        .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_ldac_n(dac_ldac_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Line monitor
    logic [15:0] fr_q [$];
    int len_q [$], falls_q [$], start_q [$], end_q [$];
    int ldac_len_q [$], ldac_fall_q [$];
    logic busy_ldac_q [$];
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_ldac = 1'b1;
    logic [15:0] bits;
    int cs_len, nfall, fstart, ldac_len, stray = 0;

    always @(negedge clk) begin
        if (prev_cs && !dac_cs_n) begin
            cs_len = 0; nfall = 0; bits = 16'd0; fstart = cyc;
        end
        if (!dac_cs_n) begin
            cs_len++;
            if (prev_sclk && !dac_sclk) begin
                bits = {bits[14:0], dac_din};
                nfall++;
            end
        end
        if (!prev_cs && dac_cs_n) begin
            fr_q.push_back(bits); len_q.push_back(cs_len); falls_q.push_back(nfall);
            start_q.push_back(fstart); end_q.push_back(cyc);
        end
        if (prev_cs && dac_cs_n && (prev_sclk != dac_sclk)) stray++;
        if (prev_ldac && !dac_ldac_n) begin
            ldac_len = 0; ldac_fall_q.push_back(cyc); busy_ldac_q.push_back(ebi.busy);
        end
        if (!dac_ldac_n) ldac_len++;
        if (!prev_ldac && dac_ldac_n) ldac_len_q.push_back(ldac_len);
        prev_cs = dac_cs_n; prev_sclk = dac_sclk; prev_ldac = dac_ldac_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic put(input logic w, input logic [18:0] a, input logic [15:0] d);
        @(negedge clk);
        ebi.wr = w; ebi.addr = a; ebi.data_in = d;
    endtask

    task automatic rd(input logic [18:0] a, output logic [15:0] v);
        put(1'b0, a, 16'd0);
        @(negedge clk);
        v = ebi.data_out;
    endtask

    task automatic clear_mon();
        fr_q.delete(); len_q.delete(); falls_q.delete(); start_q.delete(); end_q.delete();
        ldac_len_q.delete(); ldac_fall_q.delete(); busy_ldac_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && fr_q.size() < n; i++) @(negedge clk);
        chk(tag, fr_q.size(), n);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!ebi.busy && dac_cs_n && dac_ldac_n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("idle_reached", ok, 1'b1);
    endtask

    task automatic wait_cs_low(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!dac_cs_n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, ok, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [12];
        logic [15:0] v, exp_ovf [10];
        logic [15:0] exp_q [$];
        int          n, k;
        logic [2:0]  ch;
        logic [15:0] d;

        ebi.wr = 1'b0; ebi.addr = 19'd0; ebi.data_in = 16'd0; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", dac_cs_n, 1'b1);
        chk("rst_sclk", dac_sclk, 1'b1);
        chk("rst_din", dac_din, 1'b0);
        chk("rst_ldac_n", dac_ldac_n, 1'b1);
        chk("rst_data_out", ebi.data_out, 16'd0);
        chk("rst_busy", ebi.busy, 1'b0);
        reset = 1'b0;

        // Idle register map: {wr, addr, data, expected data_out one cycle later}
        vt[0]  = '{1'b0, BASE + 19'd1,  16'h0000, 16'h0000};
        vt[1]  = '{1'b0, BASE + 19'd0,  16'h0000, 16'h0000};
        vt[2]  = '{1'b0, BASE + 19'd2,  16'h0000, 16'h0000};
        vt[3]  = '{1'b0, BASE + 19'd9,  16'h0000, 16'h0000};
        vt[4]  = '{1'b0, BASE + 19'd10, 16'h0000, 16'h0000};
        vt[5]  = '{1'b0, 19'h00001,     16'h0000, 16'h0000};
        vt[6]  = '{1'b1, 19'h00005,     16'h0FFF, 16'h0000};
        vt[7]  = '{1'b0, BASE + 19'd1,  16'h0000, 16'h0000};
        vt[8]  = '{1'b1, BASE + 19'd0,  16'h0004, 16'h0000};
        vt[9]  = '{1'b0, BASE + 19'd1,  16'h0000, 16'h0000};
        vt[10] = '{1'b1, BASE + 19'd0,  16'h0001, 16'h0000};
        vt[11] = '{1'b0, 19'h7FF01,     16'h0000, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            put(vt[i].wr, vt[i].addr, vt[i].din);
            put(1'b0, vt[i].addr, 16'd0);
            chk($sformatf("vec%0d", i), ebi.data_out, vt[i].exp);
        end
        repeat (200) @(negedge clk);
        chk("foreign_window_frames", fr_q.size(), 0);

        // Single frame: 12'hABC on channel 3
        clear_mon();
        put(1'b1, BASE + 19'd5, 16'h0ABC);
        put(1'b0, BASE + 19'd1, 16'd0);
        repeat (5) @(negedge clk);
        chk("busy_in_frame", ebi.busy, 1'b1);
        wait_frames(1, 400, "single_frame_seen");
        if (fr_q.size() >= 1) begin
            chk("single_bits", fr_q[0], 16'h3ABC);
            chk("single_cs_len", len_q[0], 32 * CD);
            chk("single_falls", falls_q[0], 16);
        end
        repeat (CD + 2) @(negedge clk);
        chk("single_gap_no_restart", fr_q.size() + (dac_cs_n ? 0 : 100), 1);

        // Ten back-to-back writes overflow the FIFO
        wait_idle();
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            exp_ovf[i] = {1'b0, 3'(i % 8), 12'(i * 16'h0111 + 16'h0005)};
            put(1'b1, BASE + 19'd2 + 19'(i % 8), 16'hF000 | 16'(i * 16'h0111 + 16'h0005));
        end
        rd(BASE + 19'd1, v);
        chk("ovf_flag_set", v[14], 1'b1);
        wait_frames(8, 9 * PERIOD + 200, "ovf_frames_min");
        repeat (PERIOD + 40) @(negedge clk);
        n = fr_q.size();
        chk("ovf_accepted_8_or_9", ((n == 8) || (n == 9)), 1'b1);
        for (int i = 0; i < n && i < 10; i++) chk($sformatf("ovf_frame%0d", i), fr_q[i], exp_ovf[i]);
        for (int i = 0; i + 1 < n; i++) chk($sformatf("ovf_period%0d", i), start_q[i+1] - start_q[i], PERIOD);
        rd(BASE + 19'd1, v);
        chk("ovf_sticky", v[14], 1'b1);
        put(1'b1, BASE + 19'd0, 16'h0004);
        rd(BASE + 19'd1, v);
        chk("ovf_cleared", v[14], 1'b0);

        // LDAC waits for queued frames, then a merged repeat request
        wait_idle();
        clear_mon();
        put(1'b1, BASE + 19'd2, 16'h0111);
        put(1'b1, BASE + 19'd3, 16'h0222);
        put(1'b1, BASE + 19'd0, 16'h0002);
        put(1'b0, BASE + 19'd1, 16'd0);
        for (int i = 0; i < 800 && ldac_len_q.size() < 1; i++) @(negedge clk);
        chk("ldac_pulse_seen", ldac_len_q.size(), 1);
        chk("ldac_frames_before", fr_q.size(), 2);
        if (ldac_len_q.size() >= 1 && end_q.size() >= 2) begin
            chk("ldac_len", ldac_len_q[0], 2 * CD);
            chk("ldac_after_gap", ldac_fall_q[0] >= end_q[1] + CD, 1'b1);
            chk("ldac_busy_during", busy_ldac_q[0], 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("ldac_busy_after", ebi.busy, 1'b0);
        rd(BASE + 19'd1, v);
        chk("ldac_status_after", v, 16'h0000);
        put(1'b1, BASE + 19'd0, 16'h0002);
        put(1'b1, BASE + 19'd0, 16'h0002);
        put(1'b0, BASE + 19'd1, 16'd0);
        repeat (60) @(negedge clk);
        chk("ldac_merged_pulses", ldac_len_q.size(), 2);

        // Reset in the middle of a frame
        wait_idle();
        clear_mon();
        put(1'b1, BASE + 19'd5, 16'h0ABC);
        put(1'b0, BASE + 19'd1, 16'd0);
        wait_cs_low("reset_frame_started");
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", dac_cs_n, 1'b1);
        chk("midrst_sclk", dac_sclk, 1'b1);
        chk("midrst_ldac_n", dac_ldac_n, 1'b1);
        chk("midrst_data_out", ebi.data_out, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_status", ebi.data_out, 16'd0);
        k = stray;
        clear_mon();
        repeat (400) @(negedge clk);
        chk("midrst_no_edges", stray - k, 0);
        chk("midrst_no_frames", fr_q.size(), 0);

        // Flush while the first of four frames is on the wire
        clear_mon();
        for (int i = 0; i < 4; i++) put(1'b1, BASE + 19'd6 + 19'(i), 16'h0100 + 16'(i));
        put(1'b0, BASE + 19'd1, 16'd0);
        wait_cs_low("flush_frame_started");
        repeat (20) @(negedge clk);
        put(1'b1, BASE + 19'd0, 16'h0001);
        rd(BASE + 19'd1, v);
        chk("flush_count", v[4:0], 5'd0);
        chk("flush_busy", v[15], 1'b1);
        repeat (600) @(negedge clk);
        chk("flush_frames", fr_q.size(), 1);
        if (fr_q.size() >= 1) chk("flush_frame0", fr_q[0], 16'h4100);

        // Shadow readback (survives a flush)
        wait_idle();
        put(1'b1, BASE + 19'd9, 16'hF123);
        rd(BASE + 19'd9, v);
`ifdef DAC_SHADOW_EN
        chk("shadow_ch7", v, 16'h0123);
        put(1'b1, BASE + 19'd0, 16'h0001);
        rd(BASE + 19'd9, v);
        chk("shadow_after_flush", v, 16'h0123);
`else
        chk("shadow_ch7_absent", v, 16'h0000);
`endif

        // Randomized bursts against the frame model
        for (int r = 0; r < 4; r++) begin
            repeat (20) @(negedge clk);
            wait_idle();
            clear_mon();
            exp_q.delete();
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                ch = 3'($urandom_range(0, 7));
                d  = 16'($urandom);
                exp_q.push_back({1'b0, ch, d[11:0]});
                put(1'b1, BASE + 19'd2 + 19'(ch), d);
                repeat ($urandom_range(0, 3)) put(1'b0, BASE + 19'd1, 16'd0);
            end
            put(1'b0, BASE + 19'd1, 16'd0);
            wait_frames(k, k * PERIOD + 300, $sformatf("rnd%0d_count", r));
            for (int i = 0; i < k && i < fr_q.size(); i++) begin
                chk($sformatf("rnd%0d_frame%0d", r, i), fr_q[i], exp_q[i]);
                chk($sformatf("rnd%0d_len%0d", r, i), len_q[i], 32 * CD);
                chk($sformatf("rnd%0d_falls%0d", r, i), falls_q[i], 16);
                if (i > 0) chk($sformatf("rnd%0d_period%0d", r, i), start_q[i] - start_q[i-1], PERIOD);
            end
            repeat (20) @(negedge clk);
            rd(BASE + 19'd1, v);
            chk($sformatf("rnd%0d_status_idle", r), v, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_control.md
Name: dac_control

Overview:
- Transmit-direction companion to the ADC controller: the EBI side writes per-channel DAC codes, and the block serialises them to an 8-channel 12-bit serial DAC.
- Uses a SYNC/SCLK/DIN/LDAC interface; SCLK is derived from the system clock.
- A small frame FIFO decouples EBI writes from the slow serial link.
- Sits beside adc_control on the shared EBI address/data bus at address window POSITION.

Parameters:
- POSITION, 0, address window index; BASE_ADDR = POSITION << 8.
- CLK_DIV, 5, clk cycles per SCLK half-period; minimum 2. 100 MHz gives 10 MHz SCLK.
- FIFO_DEPTH, 8, frame queue depth; power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- addr  in  19  EBI word address
- data_in  in  16  EBI write data
- wr  in  1  one-cycle write strobe, qualifies addr/data_in
- data_out  out  16  registered read data
- busy  out  1  engine active, FIFO non-empty, or LDAC pending
- dac_cs_n  out  1  SYNC, active low
- dac_sclk  out  1  serial clock, idles high
- dac_din  out  1  serial data, MSB first
- dac_ldac_n  out  1  load-DAC strobe, active low

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- Address map (offsets from BASE_ADDR):
  - +0 CTRL, write only: bit0 flush FIFO; bit1 request LDAC pulse; bit2 clear overflow.
  - +1 STATUS, read.
  - +2..+9 channel 0..7 write.
- Channel write (wr with addr = BASE+2+n): push frame {1'b0, n[2:0], data_in[11:0]}. data_in[15:12] is ignored.
- Write when FIFO full: frame dropped, sticky overflow set. Push and pop in the same cycle when full: push accepted.
- Flush: FIFO empty next cycle. A frame already in the shift engine completes.
- STATUS word: [15] busy, [14] overflow, [13] ldac_pending, [4:0] FIFO count (0..FIFO_DEPTH), other bits 0.
- data_out: registered every clk from addr; 1-cycle latency. Unmapped addresses read 0.
- Serial engine states:
  - IDLE, SHIFT, GAP, LDAC.
  - IDLE:
    - FIFO non-empty: pop into 16-bit shift register; dac_cs_n low and dac_din = bit15 on the next cycle (enter SHIFT).
    - Else if ldac_pending: enter LDAC.
  - SHIFT: divider counts 0..CLK_DIV-1 from SHIFT entry (cycle 0).
    - dac_sclk falls at cycle (2k+1)*CLK_DIV; the DAC samples here.
    - dac_sclk rises at (2k+2)*CLK_DIV; the shift register advances and dac_din updates on the rise, for k = 0..15.
    - At cycle 32*CLK_DIV, dac_cs_n goes high → GAP.
  - GAP: hold dac_cs_n high CLK_DIV cycles → IDLE.
  - Back-to-back frame period: 33*CLK_DIV+1 cycles (166 at default).
  - LDAC: dac_ldac_n low 2*CLK_DIV cycles, clear ldac_pending → IDLE.
- LDAC ordering: an LDAC request waits until the FIFO is empty and the engine is idle, so all queued codes load together. A repeat request while pending is merged.
- Reset values:
  - dac_cs_n=1, dac_sclk=1, dac_din=0, dac_ldac_n=1, data_out=0, busy=0.
  - FIFO empty, overflow=0, ldac_pending=0, state IDLE.
- Reset mid-frame: the frame is aborted and lines return to idle on the next cycle.

Optional Feature:
- Macro: DAC_SHADOW_EN.
- Defined:
  - 8×12-bit shadow registers, updated on each accepted channel write (not dropped ones).
  - Reads of BASE+2+n return {4'b0, shadow[n]}.
  - Shadows reset to 0 and are not touched by flush.
- Undefined: reads of BASE+2..+9 return 0 and no shadow storage is built.

Test Plan:
- Write 12'hABC to channel 3 (BASE+5), CLK_DIV=5:
  - dac_cs_n low for exactly 160 cycles.
  - 16 SCLK falls; bits sampled on the falls = 16'h3ABC, MSB first.
  - dac_cs_n high ≥5 cycles afterwards.
- Ten back-to-back channel writes:
  - 8 or 9 frames accepted (depends on pop timing).
  - Remainder dropped; STATUS[14]=1.
  - Transmitted frames in write order, period 166 cycles.
  - CTRL bit2 clears overflow.
- Write ch0, ch1, then CTRL bit1:
  - dac_ldac_n pulses low for 10 cycles, only after the second frame's GAP ends.
  - busy falls after the pulse.
- Assert reset at cycle 50 of a frame: next cycle dac_cs_n=1, dac_sclk=1, STATUS reads 0, no further SCLK edges.
- Queue 4 frames, then flush during frame 1: frame 1 completes, no further frames, STATUS[4:0]=0.
- DAC_SHADOW_EN defined: write 12'h123 to ch7, read BASE+9 → 16'h0123 one cycle later. Undefined → 0.
